// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle CPU main control FSM: Moore control decode per state with mem_ready handshakes.
// Optional jump support is enabled by defining MC_CTRL_JUMP_EN.
module mc_ctrl_fsm (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] opcode_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [2:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_o,
    output logic [3:0] state_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        IMM_EXEC  = 4'd9,
`ifdef MC_CTRL_JUMP_EN
        IMM_WB    = 4'd10,
        JUMP      = 4'd11
`else
        IMM_WB    = 4'd10
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    state_t     state_reg, state_next;
    logic [5:0] op_q_reg, op_q_next;
    ctrl_t      ctrl_c;
    ctrl_t      ctrl_gated;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= FETCH;
            op_q_reg  <= 6'd0;
        end else begin
            state_reg <= state_next;
            op_q_reg  <= op_q_next;
        end
    end

    always_comb begin
        ctrl_c     = '0;
        state_next = state_reg;
        op_q_next  = op_q_reg;
        case (state_reg)
            FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.alu_src_b = 2'b01;
                ctrl_c.ir_write  = mem_ready_i;
                ctrl_c.pc_write  = mem_ready_i;
                if (mem_ready_i)
                    state_next = DECODE;
            end
            DECODE: begin
                ctrl_c.alu_src_b = 2'b11;
                op_q_next        = opcode_i;
                case (opcode_i)
                    OP_LW, OP_SW:     state_next = MEM_ADDR;
                    OP_RTYPE:         state_next = EXECUTE;
                    OP_BEQ:           state_next = BRANCH;
                    OP_ADDI, OP_SLTI: state_next = IMM_EXEC;
`ifdef MC_CTRL_JUMP_EN
                    OP_J:             state_next = JUMP;
`endif
                    default: begin
                        ctrl_c.illegal = 1'b1;
                        state_next     = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                state_next       = (op_q_reg == OP_LW) ? MEM_READ : MEM_WRITE;
            end
            MEM_READ: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = 1'b1;
                if (mem_ready_i)
                    state_next = MEM_WB;
            end
            MEM_WB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                state_next        = FETCH;
            end
            MEM_WRITE: begin
                ctrl_c.mem_write = 1'b1;
                ctrl_c.i_or_d    = 1'b1;
                if (mem_ready_i)
                    state_next = FETCH;
            end
            EXECUTE: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_op    = 3'b010;
                state_next       = R_WB;
            end
            R_WB: begin
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                state_next       = FETCH;
            end
            BRANCH: begin
                ctrl_c.alu_src_a     = 1'b1;
                ctrl_c.alu_op        = 3'b001;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.pc_source     = 2'b01;
                state_next           = FETCH;
            end
            IMM_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = 2'b10;
                ctrl_c.alu_op    = (op_q_reg == OP_SLTI) ? 3'b011 : 3'b000;
                state_next       = IMM_WB;
            end
            IMM_WB: begin
                ctrl_c.reg_write = 1'b1;
                state_next       = FETCH;
            end
`ifdef MC_CTRL_JUMP_EN
            JUMP: begin
                ctrl_c.pc_write  = 1'b1;
                ctrl_c.pc_source = 2'b10;
                state_next       = FETCH;
            end
`endif
            // Unused encodings recover to FETCH.
            default: state_next = FETCH;
        endcase
    end

    // Reset forces every strobe low so an aborted instruction cannot write anything.
    assign ctrl_gated      = rst_i ? '0 : ctrl_c;
    assign pc_write_o      = ctrl_gated.pc_write;
    assign pc_write_cond_o = ctrl_gated.pc_write_cond;
    assign i_or_d_o        = ctrl_gated.i_or_d;
    assign mem_read_o      = ctrl_gated.mem_read;
    assign mem_write_o     = ctrl_gated.mem_write;
    assign ir_write_o      = ctrl_gated.ir_write;
    assign mem_to_reg_o    = ctrl_gated.mem_to_reg;
    assign reg_write_o     = ctrl_gated.reg_write;
    assign reg_dst_o       = ctrl_gated.reg_dst;
    assign alu_src_a_o     = ctrl_gated.alu_src_a;
    assign alu_src_b_o     = ctrl_gated.alu_src_b;
    assign alu_op_o        = ctrl_gated.alu_op;
    assign pc_source_o     = ctrl_gated.pc_source;
    assign illegal_o       = ctrl_gated.illegal;
    assign state_o         = rst_i ? 4'd0 : state_reg;

endmodule

// File: doc/mc_ctrl_fsm.md
MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 The block SHALL be clocked by clk_i and reset by rst_i; there is one clock, and reset is synchronous and active-high.
REQ-002 Ports SHALL be, clock and reset first:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  sync active-high reset
- opcode_i  in  6  instruction opcode from IR
- mem_ready_i  in  1  memory completes access this cycle
- pc_write_o  out  1  unconditional PC write
- pc_write_cond_o  out  1  PC write if ALU zero
- i_or_d_o  out  1  memory address select, 0=PC, 1=ALUOut
- mem_read_o  out  1  memory read strobe
- mem_write_o  out  1  memory write strobe
- ir_write_o  out  1  IR load
- mem_to_reg_o  out  1  writeback select, 1=MDR
- reg_write_o  out  1  register file write
- reg_dst_o  out  1  1=rd, 0=rt
- alu_src_a_o  out  1  0=PC, 1=rs
- alu_src_b_o  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_op_o  out  3  to ALU control: 000 add, 001 sub, 010 R-type funct, 011 slt
- pc_source_o  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_o  out  1  one-cycle pulse on unsupported opcode
- state_o  out  4  current state, debug

Function
REQ-003 The state register SHALL use this encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, IMM_EXEC=9, IMM_WB=10, JUMP=11; codes 12-15 SHALL go to FETCH on the next cycle.
REQ-004 Outputs SHALL be Moore, decoded from the current state only, except the mem_ready_i gating in REQ-005/REQ-008; unlisted outputs in each state SHALL be 0.
REQ-005 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00; ir_write and pc_write=mem_ready_i; go to DECODE when mem_ready_i=1, else stay.
REQ-006 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000; sample opcode_i into op_q.
- 100011 or 101011 -> MEM_ADDR
- 000000 -> EXECUTE
- 000100 -> BRANCH
- 001000 or 001010 -> IMM_EXEC
- 000010 -> JUMP (see REQ-016)
- any other opcode -> FETCH, with illegal_o=1 that cycle
REQ-007 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000; go to MEM_READ if op_q=100011, else MEM_WRITE.
REQ-008 MEM_READ drives mem_read=1, i_or_d=1; MEM_WRITE drives mem_write=1, i_or_d=1; each state holds until mem_ready_i=1. MEM_READ then goes to MEM_WB; MEM_WRITE then goes to FETCH.
REQ-009 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; go to FETCH.
REQ-010 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=010; go to R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; go to FETCH.
REQ-011 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01; go to FETCH.
REQ-012 IMM_EXEC: alu_src_a=1, alu_src_b=10; alu_op=000 if op_q=001000, alu_op=011 if op_q=001010; go to IMM_WB. IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0; go to FETCH.
REQ-013 Cycle counts with mem_ready_i held at 1: R-type, addi, slti = 4; beq, j = 3; sw = 4; lw = 5. Each cycle mem_ready_i=0 in a memory state SHALL add one cycle.
REQ-014 mem_write_o and mem_read_o SHALL never be 1 in the same cycle; reg_write_o and any PC write SHALL never be 1 in the same cycle.

Reset
REQ-015 While rst_i=1 at a rising edge, the next state SHALL be FETCH and op_q SHALL be 000000. While rst_i=1, all control outputs and illegal_o SHALL be forced to 0 and state_o SHALL read 0. Reset asserted mid-instruction SHALL abort it with no further writes.

Configuration
REQ-016 The macro MC_CTRL_JUMP_EN SHALL control jump support.
- Defined: opcode 000010 goes DECODE->JUMP; JUMP drives pc_write=1, pc_source=10, then goes to FETCH.
- Undefined: state JUMP is not implemented, and 000010 SHALL be handled as an illegal opcode (FETCH, illegal_o pulse); pc_source_o=10 SHALL never occur.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- Reset, then rst_i=0 with mem_ready_i=1 -> state_o 0 with mem_read_o=1, then 1 next cycle.
- opcode 000000, ready=1 -> states 0,1,6,7,0; alu_op_o=010 in state 6; reg_write_o=1 and reg_dst_o=1 in state 7.
- lw (100011) with mem_ready_i low 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0; mem_to_reg_o=1 in state 4.
- slti (001010) -> alu_op_o=011 in state 9; addi (001000) -> alu_op_o=000 in state 9; beq -> alu_op_o=001 with pc_write_cond_o=1 in state 8.
- opcode 111111 -> illegal_o=1 for exactly one cycle in DECODE, next state 0, no write strobes; j (000010) gives states 0,1,11,0 with the macro defined, and an illegal pulse without it.
- rst_i raised during MEM_WRITE with ready low -> mem_write_o=0 that cycle, state 0 after release.
